sitcpxg_tx_feeder: RTL and testbench

SITCPXG_TX_FEEDER -- requirements
Module: sitcpxg_tx_feeder

---
 rtl/sitcpxg_tx_feeder.sv | 194 +++++++++++++++++++
 tb/tb_sitcpxg_tx_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sitcpxg_tx_feeder.sv
// sitcpxg_tx_feeder
// Forwards a byte-counted 64-bit source stream into the SiTCP-XG user TX port
// for the lifetime of one TCP session. It drains for a fixed number of idle
// cycles before acknowledging a close request, counts the bytes delivered, and
// discards words whose byte count is illegal.
module sitcpxg_tx_feeder #(
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        XGMII_CLOCK,
  input  logic        RSTs,
  input  logic [63:0] SRC_D,
  input  logic [3:0]  SRC_B,
  input  logic        SRC_VALID,
  output logic        SRC_READY,
  input  logic        USER_SESSION_ESTABLISHED,
  input  logic        USER_SESSION_CLOSE_REQ,
  output logic        USER_SESSION_CLOSE_ACK,
  input  logic        USER_TX_AFULL,
  output logic [63:0] USER_TX_D,
  output logic [3:0]  USER_TX_B,
  output logic [31:0] TX_BYTE_CNT,
  output logic [7:0]  ERR_CNT,
  output logic [1:0]  STATE
);

  // The drain counter only has to reach DRAIN_CYCLES-1.
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [DCW-1:0] drain_cnt_r;
  logic           drain_done_s;
  logic           open_s;
  logic           xfer_en_s;
  logic           xfer_s;
  logic [63:0]    tx_d_r;
  logic [3:0]     tx_b_r;
  logic [31:0]    tx_byte_cnt_r;
  logic [7:0]     err_cnt_r;

  // A byte count is deliverable only in the range 1..8.
  function automatic logic is_legal_count(input logic [3:0] b);
    is_legal_count = (b != 4'd0) && (b <= 4'd8);
  endfunction

  // Error counter increment that sticks at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  // Everything except AFULL is folded into xfer_en_s, so AFULL only sees the
  // final AND on its way to SRC_READY. A pending close or reset blocks the
  // handshake in the same cycle.
  assign xfer_en_s    = (state_r == S_XFER) && !USER_SESSION_CLOSE_REQ && !RSTs;
  assign xfer_s       = SRC_VALID && SRC_READY;
  assign drain_done_s = (state_r == S_DRAIN) && (drain_cnt_r == DRAIN_LAST);

  // State register.
  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; open_s marks the start of a new session.
  always_comb begin
    state_nxt_s = state_r;
    open_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (USER_SESSION_ESTABLISHED && !USER_SESSION_CLOSE_REQ) begin
          state_nxt_s = S_XFER;
          open_s      = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_XFER: begin
        if (USER_SESSION_CLOSE_REQ) begin
          state_nxt_s = S_DRAIN;
        end else if (!USER_SESSION_ESTABLISHED) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_XFER;
        end
      end
      S_DRAIN: begin
        if (drain_done_s) begin
          state_nxt_s = S_CLOSE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_CLOSE: begin
        if (!USER_SESSION_CLOSE_REQ) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CLOSE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    SRC_READY              = 1'b0;
    USER_SESSION_CLOSE_ACK = 1'b0;
    case (state_r)
      S_XFER: begin
        SRC_READY = xfer_en_s & ~USER_TX_AFULL;
      end
      S_CLOSE: begin
        USER_SESSION_CLOSE_ACK = 1'b1;
      end
      default: begin
        SRC_READY              = 1'b0;
        USER_SESSION_CLOSE_ACK = 1'b0;
      end
    endcase
  end

  // Drain counter: runs only while in DRAIN, otherwise parked at zero.
  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      drain_cnt_r <= '0;
    end else if ((state_r == S_DRAIN) && !drain_done_s) begin
      drain_cnt_r <= drain_cnt_r + 1'b1;
    end else begin
      drain_cnt_r <= '0;
    end
  end

  // Write port: a legal word appears one cycle after its handshake, for one
  // cycle; the data bus keeps its last value when there is no write.
  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      tx_d_r <= 64'd0;
      tx_b_r <= 4'd0;
    end else if (xfer_s && is_legal_count(SRC_B)) begin
      tx_d_r <= SRC_D;
      tx_b_r <= SRC_B;
    end else begin
      tx_b_r <= 4'd0;
    end
  end

  // Session byte counter: cleared when a session opens, wraps at 2^32.
  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      tx_byte_cnt_r <= 32'd0;
    end else if (open_s) begin
      tx_byte_cnt_r <= 32'd0;
    end else if (xfer_s && is_legal_count(SRC_B)) begin
      tx_byte_cnt_r <= tx_byte_cnt_r + {28'd0, SRC_B};
    end else begin
      tx_byte_cnt_r <= tx_byte_cnt_r;
    end
  end

  // Discarded-word counter for illegal byte counts.
  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      err_cnt_r <= 8'd0;
    end else if (xfer_s && !is_legal_count(SRC_B)) begin
      err_cnt_r <= sat_inc8(err_cnt_r);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign USER_TX_D   = tx_d_r;
  assign USER_TX_B   = tx_b_r;
  assign TX_BYTE_CNT = tx_byte_cnt_r;
  assign ERR_CNT     = err_cnt_r;
  assign STATE       = state_r;

endmodule

// File: tb/tb_sitcpxg_tx_feeder.sv
// Testbench for sitcpxg_tx_feeder: directed session scenarios plus a random
// stream, all checked against a cycle-level behavioural model of the feeder.
module tb_sitcpxg_tx_feeder;

  localparam int DRAIN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] src_d;
  logic [3:0]  src_b;
  logic        src_valid;
  logic        src_ready;
  logic        est;
  logic        creq;
  logic        ack;
  logic        afull;
  logic [63:0] tx_d;
  logic [3:0]  tx_b;
  logic [31:0] byte_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  always #5 clk = ~clk;

  sitcpxg_tx_feeder #(.DRAIN_CYCLES(DRAIN)) dut (
    .XGMII_CLOCK              (clk),
    .RSTs                     (rst),
    .SRC_D                    (src_d),
    .SRC_B                    (src_b),
    .SRC_VALID                (src_valid),
    .SRC_READY                (src_ready),
    .USER_SESSION_ESTABLISHED (est),
    .USER_SESSION_CLOSE_REQ   (creq),
    .USER_SESSION_CLOSE_ACK   (ack),
    .USER_TX_AFULL            (afull),
    .USER_TX_D                (tx_d),
    .USER_TX_B                (tx_b),
    .TX_BYTE_CNT              (byte_cnt),
    .ERR_CNT                  (err_cnt),
    .STATE                    (state)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: session phase (0 idle, 1 transferring, 2 draining,
  // 3 closing), remaining drain cycles, and the expected port values.
  int          m_phase      = 0;
  int          m_drain_left = 0;
  int          m_errs       = 0;
  logic [31:0] m_bytes      = 32'd0;
  logic [63:0] m_d          = 64'd0;
  logic [3:0]  m_b          = 4'd0;
  bit          last_accept  = 1'b0;

  int pulses;
  int ready_low;
  int drain_seen;
  int ack_seen;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (m_phase == 1) && !creq && !afull && !rst;
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit accept;
    accept      = model_ready() && src_valid;
    last_accept = accept;
    if (rst) begin
      m_phase = 0; m_drain_left = 0; m_errs = 0;
      m_bytes = 32'd0; m_d = 64'd0; m_b = 4'd0;
      return;
    end
    m_b = 4'd0;
    if (accept) begin
      if (src_b >= 4'd1 && src_b <= 4'd8) begin
        m_b     = src_b;
        m_d     = src_d;
        m_bytes = m_bytes + 32'(src_b);
      end else if (m_errs < 255) begin
        m_errs++;
      end
    end
    case (m_phase)
      0: if (est && !creq) begin m_phase = 1; m_bytes = 32'd0; end
      1: if (creq) begin m_phase = 2; m_drain_left = DRAIN; end
         else if (!est) m_phase = 0;
      2: begin m_drain_left--; if (m_drain_left == 0) m_phase = 3; end
      3: if (!creq) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  // One clock cycle: inputs were set at the preceding falling edge.
  task automatic run_cycle();
    #1;
    check_eq("src_ready", 64'(src_ready), 64'(model_ready()));
    if (!src_ready) ready_low++;
    @(posedge clk);
    model_edge();
    #1;
    check_eq("state",    64'(state),    64'(m_phase));
    check_eq("tx_b",     64'(tx_b),     64'(m_b));
    check_eq("tx_d",     tx_d,          m_d);
    check_eq("byte_cnt", 64'(byte_cnt), 64'(m_bytes));
    check_eq("err_cnt",  64'(err_cnt),  64'(m_errs));
    check_eq("ack",      64'(ack),      64'(m_phase == 3));
    if (tx_b != 4'd0) pulses++;
    if (state == 2'd2) drain_seen++;
    if (ack) ack_seen++;
    @(negedge clk);
  endtask

  task automatic clear_counts();
    pulses = 0; ready_low = 0; drain_seen = 0; ack_seen = 0;
  endtask

  initial begin
    rst = 1'b1; est = 1'b0; creq = 1'b0; afull = 1'b0;
    src_valid = 1'b0; src_b = 4'd0; src_d = 64'd0;
    clear_counts();
    @(negedge clk);

    // Reset values.
    repeat (2) run_cycle();
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_ready", 64'(src_ready), 64'd0);
    check_eq("rst_tx_b", 64'(tx_b), 64'd0);
    check_eq("rst_tx_d", tx_d, 64'd0);
    check_eq("rst_ack", 64'(ack), 64'd0);
    check_eq("rst_bytes", 64'(byte_cnt), 64'd0);
    check_eq("rst_errs", 64'(err_cnt), 64'd0);
    rst = 1'b0;

    // Four full words back to back.
    est = 1'b1;
    run_cycle();
    clear_counts();
    for (int i = 1; i <= 4; i++) begin
      src_valid = 1'b1; src_b = 4'd8; src_d = 64'(i);
      run_cycle();
    end
    src_valid = 1'b0;
    run_cycle();
    check_eq("burst_pulses", 64'(pulses), 64'd4);
    check_eq("burst_bytes", 64'(byte_cnt), 64'd32);
    check_eq("burst_last_d", tx_d, 64'd4);

    // AFULL for three cycles holds the word; it is delivered once afterwards.
    clear_counts();
    src_valid = 1'b1; src_b = 4'd8; src_d = 64'h55; afull = 1'b1;
    repeat (3) run_cycle();
    afull = 1'b0;
    run_cycle();
    src_valid = 1'b0;
    run_cycle();
    check_eq("afull_ready_low", 64'(ready_low), 64'd3);
    check_eq("afull_pulses", 64'(pulses), 64'd1);
    check_eq("afull_d", tx_d, 64'h55);
    check_eq("afull_bytes", 64'(byte_cnt), 64'd40);

    // Illegal byte counts are consumed and counted.
    clear_counts();
    src_valid = 1'b1; src_d = 64'hBAD0; src_b = 4'd0;
    run_cycle();
    src_b = 4'd12;
    run_cycle();
    src_valid = 1'b0;
    run_cycle();
    check_eq("illegal_errs", 64'(err_cnt), 64'd2);
    check_eq("illegal_bytes", 64'(byte_cnt), 64'd40);
    check_eq("illegal_pulses", 64'(pulses), 64'd0);
    src_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      src_b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      run_cycle();
    end
    src_valid = 1'b0;
    run_cycle();
    check_eq("err_saturate", 64'(err_cnt), 64'd255);

    // Byte counter wrap, then cleared by a new session.
    force dut.tx_byte_cnt_r = 32'hFFFF_FFFC;
    #1;
    release dut.tx_byte_cnt_r;
    m_bytes = 32'hFFFF_FFFC;
    src_valid = 1'b1; src_b = 4'd8; src_d = 64'hA5A5;
    run_cycle();
    src_valid = 1'b0;
    check_eq("wrap_bytes", 64'(byte_cnt), 64'h4);
    est = 1'b0;
    run_cycle();
    est = 1'b1;
    run_cycle();
    check_eq("session_clear", 64'(byte_cnt), 64'd0);

    // Close request coincident with a valid word: no transfer, full drain.
    clear_counts();
    src_valid = 1'b1; src_b = 4'd8; src_d = 64'h77; creq = 1'b1;
    repeat (20) run_cycle();
    src_valid = 1'b0; creq = 1'b0;
    run_cycle();
    check_eq("close_pulses", 64'(pulses), 64'd0);
    check_eq("close_drain", 64'(drain_seen), 64'd16);
    check_eq("close_ack", 64'(ack_seen), 64'd4);
    check_eq("close_state", 64'(state), 64'd0);

    // IDLE must not reopen while a close request is pending.
    creq = 1'b1;
    repeat (2) run_cycle();
    check_eq("idle_hold", 64'(state), 64'd0);
    creq = 1'b0;
    run_cycle();

    // Close request dropped during DRAIN: drain completes, ACK lasts one cycle.
    creq = 1'b1;
    run_cycle();
    clear_counts();
    creq = 1'b0;
    repeat (18) run_cycle();
    check_eq("drop_ack", 64'(ack_seen), 64'd1);
    check_eq("drop_drain", 64'(drain_seen), 64'd15);

    // Reset pulsed while ACK is asserted.
    creq = 1'b1;
    repeat (17) run_cycle();
    check_eq("close_reached", 64'(state), 64'd3);
    check_eq("close_ack_on", 64'(ack), 64'd1);
    rst = 1'b1;
    run_cycle();
    check_eq("rst_close_ack", 64'(ack), 64'd0);
    check_eq("rst_close_state", 64'(state), 64'd0);
    check_eq("rst_close_tx_b", 64'(tx_b), 64'd0);
    rst = 1'b0; creq = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      afull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) est = ~est;
      if (!creq) begin
        creq = ($urandom_range(0, 149) == 0);
      end else if (m_phase == 3) begin
        creq = ($urandom_range(0, 3) != 0);
      end else if ($urandom_range(0, 39) == 0) begin
        creq = 1'b0;
      end
      rst = ($urandom_range(0, 499) == 0);
      if (!src_valid || last_accept) begin
        if ($urandom_range(0, 3) != 0) begin
          src_valid = 1'b1;
          src_d     = {$urandom, $urandom};
          src_b     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(1, 8));
        end else begin
          src_valid = 1'b0;
        end
      end
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
